// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame sizes, FIFO default
// depth and the frame/parity helpers used when a frame is loaded.
package uart_pkg;

  // Transmitter controller states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Frame lengths: start + 8 data + parity + 1 or 2 stop bits.
  localparam int FRAME_BITS_1STOP = 11;
  localparam int FRAME_BITS_2STOP = 12;

  // Default TX FIFO depth (must stay a power of two).
  localparam int FIFO_DEPTH_DEF = 8;

  // Width of the frame shift register; always sized for the longer frame.
  localparam int FRAME_W = FRAME_BITS_2STOP;

  // Parity bit: even_sel=1 gives even parity (^data), 0 gives odd parity.
  function automatic logic parity_bit(input logic [7:0] data, input logic even_sel);
    return even_sel ? (^data) : (~^data);
  endfunction

  // Full 12-bit frame image, LSB first on the line. Both stop-bit positions
  // are ones, so the one/two stop bit choice lives only in the bit counter.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data,
                                                     input logic       even_sel);
    return {2'b11, parity_bit(data, even_sel), data, 1'b0};
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Circular buffer with wrapping
// read/write pointers, registered occupancy count and full/empty flags.
// A push while full is dropped; a pop while empty is ignored.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok;
  logic          pop_ok;

  // Qualify requests against the registered flags, so a push into an empty
  // FIFO can only be popped on a later edge.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Next-state for pointers, count and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage: written only on an accepted push, so dropped pushes leave data intact.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: bytes queued in tx_fifo are framed (start, 8 data LSB
// first, parity, 1 or 2 stop bits) and shifted out on tx_out. Queued frames
// follow each other with no idle gap. Baud divisor, parity select and stop
// bit count are sampled when a frame is loaded and held for that frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DIV_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_divisor,
  input  logic             parity_sel,
  input  logic             two_stop_bits,
  input  logic [7:0]       data_in,
  input  logic             wr_en,
  output logic             tx_out,
  output logic             fifo_full,
  output logic [3:0]       fifo_count,
  output logic             tx_busy,
  output tx_state_t        dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t          state_q, state_d;
  logic [DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  logic               pop;
  logic               load;
  logic [7:0]         head_data;
  logic               fifo_empty;
  logic [CW-1:0]      count;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en),
    .wdata_i (data_in),
    .pop_i   (pop),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Controller: next state, counters, shift register and FIFO pop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (baud_cnt_q == div_q) begin
          if (bit_cnt_q == 4'd1) begin
            // End of the last stop bit: chain the next frame or go quiet.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d    = {1'b1, shift_q[FRAME_W-1:1]};
            bit_cnt_d  = bit_cnt_q - 4'd1;
            baud_cnt_d = '0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame load shared by the idle start and the back-to-back chain.
    if (load) begin
      state_d    = SEND;
      shift_d    = build_frame(head_data, parity_sel);
      bit_cnt_d  = two_stop_bits ? 4'(FRAME_BITS_2STOP) : 4'(FRAME_BITS_1STOP);
      baud_cnt_d = '0;
      div_d      = baud_divisor;
    end
    pop = load;
  end

  // Controller registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Line is driven from registered state, so an asynchronous reset idles it
  // high at once.
  assign tx_out      = (state_q == SEND) ? shift_q[0] : 1'b1;
  assign tx_busy     = (state_q == SEND);
  assign fifo_count  = 4'(count);
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the processor-side UART, the transmit direction matching the existing receiver. It uses the same frame format and configuration inputs (12-bit baud divisor, parity select, one or two stop bits). The processor pushes bytes into an 8-entry FIFO. A controller pops each byte and shifts out the frame LSB-first on `tx_out`, sending queued frames back to back.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two.
- `DIV_W`, default 12: baud divisor width.

Ports:
- `clk` in 1: system clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `baud_divisor` in DIV_W: each bit is held for `baud_divisor+1` clk cycles.
- `parity_sel` in 1: 1 = even parity, 0 = odd parity.
- `two_stop_bits` in 1: 1 = two stop bits, 0 = one stop bit.
- `data_in` in 8: byte to transmit.
- `wr_en` in 1: push request. Accepted only when `fifo_full`=0.
- `tx_out` out 1: serial line. Idle level is 1.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `fifo_count` out 4: number of bytes stored in the FIFO.
- `tx_busy` out 1: a frame is being shifted out.

## Operation
- Frame order:
  - start bit (0);
  - `data[0]` through `data[7]`;
  - parity bit;
  - stop bit (1), plus a second stop bit (1) when `two_stop_bits`=1.
  - Total frame length is 11 or 12 bits.
- Parity bit: with `parity_sel`=1 it is `^data`; with `parity_sel`=0 it is `~^data`. In both cases it is computed at frame load.
- Configuration is captured when a frame is loaded: `baud_divisor`, `parity_sel` and `two_stop_bits`. Changing them mid-frame affects only later frames.
- FSM states:
  - IDLE: `tx_out`=1, `tx_busy`=0. If the FIFO is non-empty: pop the head byte, load the frame shift register and bit counter, clear the baud counter, and go to SEND.
  - SEND: `tx_out` = shift register bit 0.
    - The baud counter counts 0..`baud_divisor`. At terminal count it shifts right by one (filling with 1), decrements the bit counter and restarts.
    - When the terminal count falls on the last bit, and the FIFO is non-empty: pop and load the next frame on that same edge, staying in SEND.
    - In that same case with an empty FIFO: go to IDLE.
- FIFO behaviour:
  - Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - `fifo_count` is the occupancy, range 0..8.
  - A push while full is ignored: no pointer or count change, and the stored data is untouched.
  - A push and a pop on the same edge leave `fifo_count` unchanged. Both pointers advance.
  - A pop is only issued when non-empty. A push into an empty FIFO is poppable on the next edge, never the same edge.

## Timing
- Reset values: `tx_out`=1, `tx_busy`=0, `fifo_full`=0, `fifo_count`=0. FSM is in IDLE, pointers are 0, all counters are 0.
- Reset asserted mid-frame: `tx_out` returns to 1 immediately (asynchronous). The frame is aborted and the FIFO is emptied.
- Push at edge E into an empty FIFO while IDLE:
  - `fifo_count`=1 after E.
  - Pop at E+1: `tx_out`=0 and `tx_busy`=1 after E+1, and `fifo_count` returns to 0.
- Each bit lasts exactly `baud_divisor+1` cycles.
- A frame occupies `N*(baud_divisor+1)` cycles, with N=11 or 12.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- `tx_busy` drops on the edge that ends the last stop bit, and only when the FIFO is empty.
- `fifo_full` and `fifo_count` are registered and reflect the state after each edge.

## Structure
- Shared package `uart_pkg`, also to be used by the receiver:
  - state enum `tx_state_t` {IDLE, SEND};
  - `FRAME_BITS_1STOP`=11 and `FRAME_BITS_2STOP`=12;
  - `FIFO_DEPTH_DEF`=8.
- Sub-module `tx_fifo`: storage, pointers, count, full/empty.
- The top level `uart_tx` holds the FSM, baud counter, bit counter, 12-bit shift register and parity generation.

## Test plan
- Reset, no writes: `tx_out`=1, `tx_busy`=0, `fifo_count`=0 for 100 cycles. Assert reset mid-frame: `tx_out`=1 immediately and `fifo_count`=0.
- Write 0x55 with `baud_divisor`=3, even parity, one stop bit:
  - line sequence 0,1,0,1,0,1,0,1,0,0,1, each bit 4 cycles;
  - 44 cycles total, then `tx_busy`=0.
- Write 0xA7 with even parity, two stop bits, `baud_divisor`=0: bits 0,1,1,1,0,0,1,0,1,1,1,1, one cycle each. Repeat with odd parity: the parity bit is 0.
- Write 10 bytes in consecutive cycles while the transmitter is idle:
  - the first byte is popped at once and the next 8 bytes fill the FIFO;
  - `fifo_full`=1 and the 10th write is dropped;
  - exactly 9 frames are sent, back to back with no gap.
- Push on the same edge as a frame-boundary pop with `fifo_count`=3: `fifo_count` stays 3. The pointers wrap past 7 and the data order is preserved.
- Change `baud_divisor` from 3 to 7 mid-frame: the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
